// File: rtl/lpif_ustrm_arb_pkg.sv
// Shared types, constants and the round-robin helper for the upstream LPIF arbiter.
package lpif_ustrm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    STALL = 2'd2
  } arb_state_e;

  localparam logic [3:0]  LPIF_STATE_ACTIVE = 4'h1;
  localparam logic [15:0] CRC16_POLY        = 16'h8005;

  // Returns {found, index}; the search begins just after the previous winner.
  function automatic logic [2:0] rr_pick(input logic [3:0] valid,
                                         input logic [1:0] last_grant,
                                         input int         num_req);
    logic [2:0] pick;
    int         idx;
    pick = 3'b000;
    for (int k = 1; k <= 4; k++) begin
      idx = (int'(last_grant) + k) % num_req;
      if (k <= num_req && !pick[2] && valid[idx[1:0]]) begin
        pick = {1'b1, idx[1:0]};
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/lpif_txrx_x2_h1_ustrm_arb_crc.sv
// Combinational 128-bit-parallel CRC-16 (poly 0x8005, init 0, MSB first, no reflection).
module lpif_crc16_d128
  import lpif_ustrm_arb_pkg::*;
(
  input  logic [127:0] i_data,
  output logic [15:0]  o_crc
);

  logic [15:0] w_crc;
  logic        w_fb;

  always_comb begin
    w_crc = '0;
    w_fb  = 1'b0;
    for (int i = 127; i >= 0; i--) begin
      w_fb  = w_crc[15] ^ i_data[i];
      w_crc = {w_crc[14:0], 1'b0} ^ (w_fb ? CRC16_POLY : 16'h0000);
    end
  end

  assign o_crc = w_crc;

endmodule

// File: rtl/lpif_txrx_x2_h1_ustrm_arb.sv
// Packet-granular round-robin scheduler for the shared x2/h1 upstream LPIF flit slot.
// Define LPIF_USTRM_CRC_EN to generate the per-flit CRC-16.
module lpif_txrx_x2_h1_ustrm_arb
  import lpif_ustrm_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                   clk_wr,
  input  logic                   rst_wr,
  input  logic [3:0]             link_state,
  input  logic                   tx_ready,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ-1:0]     req_last,
  input  logic [NUM_REQ*128-1:0] req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [3:0]             ustrm_state,
  output logic [1:0]             ustrm_protid,
  output logic [127:0]           ustrm_data,
  output logic                   ustrm_dvalid,
  output logic [15:0]            ustrm_crc,
  output logic                   ustrm_crc_valid,
  output logic                   ustrm_valid
);

  arb_state_e   r_state, w_next;
  logic [1:0]   r_owner, r_last_grant;
  logic [3:0]   w_valid4, w_last4, w_ready4;
  logic [2:0]   w_pick;
  logic [1:0]   w_sel;
  logic         w_grant, w_accept, w_active;
  logic [127:0] w_beat;

  logic [3:0]   r_state_o;
  logic [1:0]   r_protid;
  logic [127:0] r_data;
  logic         r_dvalid, r_valid;

  assign w_active = (link_state == LPIF_STATE_ACTIVE);

  always_comb begin
    w_valid4 = '0;
    w_last4  = '0;
    w_valid4[NUM_REQ-1:0] = req_valid;
    w_last4[NUM_REQ-1:0]  = req_last;
    w_pick   = rr_pick(w_valid4, r_last_grant, NUM_REQ);
    w_next   = r_state;
    w_ready4 = '0;
    w_grant  = 1'b0;
    w_sel    = r_owner;
    case (r_state)
      IDLE: begin
        if (tx_ready && w_active && w_pick[2]) begin
          w_grant           = 1'b1;
          w_sel             = w_pick[1:0];
          w_ready4[w_sel]   = 1'b1;
          if (!w_last4[w_sel]) w_next = BUSY;
        end
      end
      BUSY: begin
        if (!w_active) begin
          w_next = STALL;
        end else if (tx_ready) begin
          w_ready4[r_owner] = 1'b1;
          if (w_valid4[r_owner] && w_last4[r_owner]) w_next = IDLE;
        end
      end
      STALL: begin
        if (w_active) w_next = BUSY;
      end
      default: w_next = IDLE;
    endcase
    // Keep requesters from seeing a grant while the arbiter is held in reset.
    if (rst_wr) w_ready4 = '0;
    w_accept = |(w_ready4 & w_valid4);
  end

  assign req_ready = w_ready4[NUM_REQ-1:0];

  always_comb begin
    w_beat = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_sel == 2'(i)) w_beat = req_data[i*128 +: 128];
    end
  end

  always_ff @(posedge clk_wr or posedge rst_wr) begin
    if (rst_wr) begin
      r_state      <= IDLE;
      r_owner      <= '0;
      r_last_grant <= 2'(NUM_REQ - 1);
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_last_grant <= w_sel;
        if (!w_last4[w_sel]) r_owner <= w_sel;
      end
    end
  end

  // Protid/data keep the last real beat across idle flits.
  always_ff @(posedge clk_wr or posedge rst_wr) begin
    if (rst_wr) begin
      r_state_o <= '0;
      r_valid   <= 1'b0;
      r_dvalid  <= 1'b0;
      r_protid  <= '0;
      r_data    <= '0;
    end else if (tx_ready) begin
      r_state_o <= link_state;
      r_valid   <= w_active;
      r_dvalid  <= w_accept;
      if (w_accept) begin
        r_protid <= w_sel;
        r_data   <= w_beat;
      end
    end
  end

  assign ustrm_state  = r_state_o;
  assign ustrm_valid  = r_valid;
  assign ustrm_dvalid = r_dvalid;
  assign ustrm_protid = r_protid;
  assign ustrm_data   = r_data;

`ifdef LPIF_USTRM_CRC_EN
  logic [15:0] w_crc;
  logic [15:0] r_crc;
  logic        r_crc_valid;

  lpif_crc16_d128 u_crc (
    .i_data (w_beat),
    .o_crc  (w_crc)
  );

  always_ff @(posedge clk_wr or posedge rst_wr) begin
    if (rst_wr) begin
      r_crc       <= '0;
      r_crc_valid <= 1'b0;
    end else if (tx_ready) begin
      r_crc_valid <= w_accept;
      if (w_accept) r_crc <= w_crc;
    end
  end

  assign ustrm_crc       = r_crc;
  assign ustrm_crc_valid = r_crc_valid;
`else
  assign ustrm_crc       = 16'h0000;
  assign ustrm_crc_valid = 1'b0;
`endif

endmodule
